// File: rtl/multi_channel_watchdog.sv
// N-channel heartbeat watchdog with warning, trip pulse and worst-case countdown.
// Define WDG_WINDOW_EN to reject kicks that arrive too early in the count window.
module multi_channel_watchdog #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ    = 1,
  parameter int TIMEOUT_SEC = 5,
  parameter int WARN_PCT    = 80,
  parameter int WIN_PCT     = 20,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] force_reset,
  output logic [NUM_CH-1:0] triggered,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] trip_pulse,
  output logic [NUM_CH-1:0] early_fault,
  output logic              any_triggered,
  output logic              any_warning,
  output logic [7:0]        min_remaining,
  output logic [3:0]        min_ch
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WARN = 2'd2, TRIP = 2'd3} state_t;

  localparam int              T_I    = CLK_FREQ * TIMEOUT_SEC;
  localparam logic [CNT_W-1:0] T_C    = CNT_W'(T_I);
  localparam logic [CNT_W-1:0] W_C    = CNT_W'(T_I * WARN_PCT / 100);
  localparam logic [CNT_W-1:0] FREQ_C = CNT_W'(CLK_FREQ);
`ifdef WDG_WINDOW_EN
  localparam logic [CNT_W-1:0] M_C    = CNT_W'(T_I * WIN_PCT / 100);
`endif

  state_t            state_r [NUM_CH];
  state_t            state_s [NUM_CH];
  logic [CNT_W-1:0]  cnt_r   [NUM_CH];
  logic [CNT_W-1:0]  cnt_s   [NUM_CH];
  logic [CNT_W-1:0]  quot_s  [NUM_CH];
  logic [7:0]        rem_s   [NUM_CH];
  logic [NUM_CH-1:0] hb_q_r, kick_s, early_r, early_s;
  logic [NUM_CH-1:0] trig_s, warn_s, pulse_s;
  logic [NUM_CH-1:0] triggered_r, warning_r, trip_pulse_r;
  logic              any_trig_r, any_warn_r, found_s;
  logic [7:0]        min_rem_s, min_rem_r;
  logic [3:0]        min_ch_s, min_ch_r;

  assign kick_s = heartbeat & ~hb_q_r;

  // Per-channel next state: disable > force_reset > kick (or start) > count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      early_s[i] = early_r[i];
      if (!enable[i]) begin
        state_s[i] = IDLE;
        cnt_s[i]   = '0;
        early_s[i] = 1'b0;
      end else if (force_reset[i]) begin
        state_s[i] = RUN;
        cnt_s[i]   = '0;
        early_s[i] = 1'b0;
      end else if (kick_s[i] || (state_r[i] == IDLE)) begin
`ifdef WDG_WINDOW_EN
        if (early_r[i]) begin
          state_s[i] = TRIP;
          cnt_s[i]   = T_C;
        end else if (kick_s[i] && (state_r[i] == RUN) && (cnt_r[i] < M_C)) begin
          state_s[i] = TRIP;
          cnt_s[i]   = T_C;
          early_s[i] = 1'b1;
        end else begin
          state_s[i] = RUN;
          cnt_s[i]   = '0;
        end
`else
        state_s[i] = RUN;
        cnt_s[i]   = '0;
`endif
      end else begin
        case (state_r[i])
          RUN, WARN: begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
            if (cnt_s[i] >= T_C) begin
              state_s[i] = TRIP;
            end else if (cnt_s[i] >= W_C) begin
              state_s[i] = WARN;
            end else begin
              state_s[i] = RUN;
            end
          end
          TRIP: begin
            state_s[i] = TRIP;
            cnt_s[i]   = T_C;
          end
          default: begin
            state_s[i] = IDLE;
            cnt_s[i]   = '0;
          end
        endcase
      end
      trig_s[i]  = (state_s[i] == TRIP);
      warn_s[i]  = (state_s[i] != IDLE) && (cnt_s[i] >= W_C);
      pulse_s[i] = (state_s[i] == TRIP) && (state_r[i] != TRIP);
    end
  end

  // Seconds remaining per channel and the smallest over enabled channels.
  always_comb begin
    min_rem_s = 8'd255;
    min_ch_s  = 4'd0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      quot_s[i] = (T_C - cnt_r[i]) / FREQ_C;
      if (state_r[i] == TRIP) begin
        rem_s[i] = 8'd0;
      end else if (quot_s[i] > CNT_W'(255)) begin
        rem_s[i] = 8'd255;
      end else begin
        rem_s[i] = quot_s[i][7:0];
      end
      if (enable[i] && (!found_s || (rem_s[i] < min_rem_s))) begin
        min_rem_s = rem_s[i];
        min_ch_s  = 4'(i);
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= '0;
      end
      hb_q_r       <= '0;
      early_r      <= '0;
      triggered_r  <= '0;
      warning_r    <= '0;
      trip_pulse_r <= '0;
      any_trig_r   <= 1'b0;
      any_warn_r   <= 1'b0;
      min_rem_r    <= 8'd255;
      min_ch_r     <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      hb_q_r       <= heartbeat & enable;
      early_r      <= early_s;
      triggered_r  <= trig_s;
      warning_r    <= warn_s;
      trip_pulse_r <= pulse_s;
      any_trig_r   <= |trig_s;
      any_warn_r   <= |warn_s;
      min_rem_r    <= min_rem_s;
      min_ch_r     <= min_ch_s;
    end
  end

  assign triggered     = triggered_r;
  assign warning       = warning_r;
  assign trip_pulse    = trip_pulse_r;
  assign early_fault   = early_r;
  assign any_triggered = any_trig_r;
  assign any_warning   = any_warn_r;
  assign min_remaining = min_rem_r;
  assign min_ch        = min_ch_r;

endmodule
